// File: rtl/slotmaker_config_store.sv
// Slot-to-card map: software writes land in a pending map and are copied to the active map in a bus-safe window.
// Optional duplicate-card rejection is built when SLOTMAKER_DUP_CHECK_EN is defined.
module slotmaker_config_store #(
  parameter logic [63:0] DEFAULT_MAP = 64'h0,
  parameter logic [7:0]  EMPTY_CARD  = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] slot,
  input  logic [7:0] card_i,
  input  logic       wr,
  output logic [7:0] card_o,
  input  logic       safe_i,
  input  logic [2:0] lookup_slot,
  output logic [7:0] lookup_card,
  output logic       commit_busy,
  output logic       map_changed,
  output logic       dup_err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0] r_state;
  logic [2:0] r_idx;
  logic [7:0] r_pending [8];
  logic [7:0] r_active  [8];
  logic [7:0] r_dirty;
  logic [7:0] r_card;
  logic [7:0] r_lookup;
  logic       w_dup;
  logic       w_wr_acc;
  logic [7:0] w_dirty_next;

`ifdef SLOTMAKER_DUP_CHECK_EN
  logic r_dup_err;

  // A card may live in only one slot; the empty id is exempt, and a slot may rewrite its own value.
  always_comb begin
    w_dup = 1'b0;
    for (int j = 0; j < 8; j++) begin
      if ((3'(j) != slot) && (r_pending[j] == card_i)) w_dup = 1'b1;
    end
    if (card_i == EMPTY_CARD) w_dup = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) r_dup_err <= 1'b0;
    else if (wr && w_dup) r_dup_err <= 1'b1;
  end

  assign dup_err = r_dup_err;
`else
  assign w_dup   = 1'b0;
  assign dup_err = 1'b0;
`endif

  assign w_wr_acc = wr & ~w_dup;

  // A write landing on the slot being scanned keeps it dirty, so the new value commits next window.
  always_comb begin
    w_dirty_next = r_dirty;
    if (r_state == ST_SCAN) w_dirty_next[r_idx] = 1'b0;
    if (w_wr_acc) w_dirty_next[slot] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int n = 0; n < 8; n++) begin
        r_pending[n] <= DEFAULT_MAP[8*n +: 8];
        r_active[n]  <= DEFAULT_MAP[8*n +: 8];
      end
      r_dirty  <= 8'h00;
      r_state  <= ST_IDLE;
      r_idx    <= 3'd0;
      r_card   <= 8'h00;
      r_lookup <= 8'h00;
    end else begin
      r_card   <= w_wr_acc ? card_i : r_pending[slot];
      r_lookup <= r_active[lookup_slot];
      r_dirty  <= w_dirty_next;
      if (w_wr_acc) r_pending[slot] <= card_i;

      case (r_state)
        ST_IDLE: begin
          if (safe_i && (|r_dirty)) begin
            r_state <= ST_SCAN;
            r_idx   <= 3'd0;
          end
        end
        ST_SCAN: begin
          if (r_dirty[r_idx]) r_active[r_idx] <= r_pending[r_idx];
          r_idx <= r_idx + 3'd1;
          if (r_idx == 3'd7) r_state <= ST_DONE;
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign card_o      = r_card;
  assign lookup_card = r_lookup;
  assign commit_busy = (r_state != ST_IDLE);
  assign map_changed = (r_state == ST_DONE);

endmodule
